// File: rtl/instr_splitter.sv
// Registered instruction-split stage feeding the immediate extender: one-entry valid/ready
// register, field slicing, EOp decode and delivered-instruction counter. Optional: SPLIT_ILLEGAL_EN.
module instr_splitter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [5:0]       opcode,
    output logic [4:0]       rs,
    output logic [4:0]       rt,
    output logic [4:0]       rd,
    output logic [4:0]       shamt,
    output logic [5:0]       funct,
    output logic [15:0]      imm16,
    output logic [25:0]      jaddr,
    output logic [1:0]       EOp,
    output logic [CNT_W-1:0] instr_cnt
`ifdef SPLIT_ILLEGAL_EN
    ,
    output logic             illegal
`endif
);

    logic [31:0] word_q;
    logic [1:0]  eop_q;
    logic        valid_q;
    logic [CNT_W-1:0] cnt_q;
    logic        load;
    logic        xfer;

    function automatic logic [1:0] eop_decode(input logic [5:0] op);
        logic [1:0] e;
        case (op)
            6'b001100, 6'b001101: e = 2'b01;
            6'b001111:            e = 2'b10;
            6'b000100, 6'b000101: e = 2'b11;
            default:              e = 2'b00;
        endcase
        return e;
    endfunction

`ifdef SPLIT_ILLEGAL_EN
    logic illegal_q;

    function automatic logic illegal_decode(input logic [31:0] w);
        logic bad;
        case (w[31:26])
            6'b000000: begin
                case (w[5:0])
                    6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                    6'b100101, 6'b101010, 6'b000000, 6'b001000: bad = 1'b0;
                    default: bad = 1'b1;
                endcase
            end
            6'b000010, 6'b000011, 6'b000100, 6'b000101, 6'b001000, 6'b001001,
            6'b001100, 6'b001101, 6'b001111, 6'b100011, 6'b101011: bad = 1'b0;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    always_ff @(posedge clk) begin
        if (reset)
            illegal_q <= 1'b0;
        else if (load)
            illegal_q <= illegal_decode(instr);
    end

    assign illegal = illegal_q;
`endif

    assign in_ready = ~valid_q | out_ready;
    assign xfer     = valid_q & out_ready;
    assign load     = in_valid & in_ready & ~flush;

    // Flush wins over load, but a transfer in the flush cycle still completes and is counted.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            word_q  <= '0;
            eop_q   <= 2'b00;
            cnt_q   <= '0;
        end else begin
            if (flush)
                valid_q <= 1'b0;
            else if (load)
                valid_q <= 1'b1;
            else if (xfer)
                valid_q <= 1'b0;

            if (load) begin
                word_q <= instr;
                eop_q  <= eop_decode(instr[31:26]);
            end

            if (xfer)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign out_valid = valid_q;
    assign opcode    = word_q[31:26];
    assign rs        = word_q[25:21];
    assign rt        = word_q[20:16];
    assign rd        = word_q[15:11];
    assign shamt     = word_q[10:6];
    assign funct     = word_q[5:0];
    assign imm16     = word_q[15:0];
    assign jaddr     = word_q[25:0];
    assign EOp       = eop_q;
    assign instr_cnt = cnt_q;

endmodule

// File: tb/tb_instr_splitter.sv
// Scoreboard bench for instr_splitter (CNT_W=4): driver pushes hand-coded expectations on accept,
// a negedge monitor pops and compares on every delivered word. Honours SPLIT_ILLEGAL_EN.
module tb_instr_splitter;

    localparam int CNT_W = 4;

    typedef struct {
        logic [31:0] w;
        logic [1:0]  eop;
        logic        ill;
    } vec_t;

    logic             clk;
    logic             reset;
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      instr;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [5:0]       opcode;
    logic [4:0]       rs, rt, rd, shamt;
    logic [5:0]       funct;
    logic [15:0]      imm16;
    logic [25:0]      jaddr;
    logic [1:0]       EOp;
    logic [CNT_W-1:0] instr_cnt;
`ifdef SPLIT_ILLEGAL_EN
    logic             illegal;
`endif

    instr_splitter #(.CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
        .imm16(imm16), .jaddr(jaddr), .EOp(EOp), .instr_cnt(instr_cnt)
`ifdef SPLIT_ILLEGAL_EN
        , .illegal(illegal)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit mon_en = 1'b0;

    vec_t q[$];
    vec_t cur;
    logic mv = 1'b0;
    logic [CNT_W-1:0] mcnt = '0;

    // Directed vectors with hand-decoded EOp and illegal flags.
    vec_t v_lui, v_ori, v_beq, v_lw, v_add, v_addi, v_andi, v_bne, v_ones, v_fc, v_badr;

    function automatic vec_t mk(input logic [31:0] w, input logic [1:0] e, input logic il);
        vec_t v;
        v.w = w; v.eop = e; v.ill = il;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v, input logic vld, input logic ordy, input logic fl);
        cur       = v;
        instr     = v.w;
        in_valid  = vld;
        out_ready = ordy;
        flush     = fl;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        flush    = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Reference model of the one-entry register and counter.
    always @(posedge clk) begin
        logic ir, xf, ld;
        if (reset) begin
            mv   = 1'b0;
            mcnt = '0;
            q.delete();
        end else begin
            ir = !mv || out_ready;
            xf = mv && out_ready;
            ld = in_valid && ir && !flush;
            if (xf) mcnt = mcnt + 1'b1;
            if (flush && mv && !xf && q.size() > 0) void'(q.pop_front());
            if (ld) q.push_back(cur);
            if (flush)   mv = 1'b0;
            else if (ld) mv = 1'b1;
            else if (xf) mv = 1'b0;
        end
    end

    always @(negedge clk) begin
        vec_t e;
        if (mon_en) begin
            chk("out_valid", {31'b0, out_valid}, {31'b0, mv});
            chk("in_ready", {31'b0, in_ready}, {31'b0, (!mv || out_ready)});
            chk("instr_cnt", {28'b0, instr_cnt}, {28'b0, mcnt});
            if (out_valid === 1'b1) begin
                if (q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL scoreboard_empty actual=out_valid=1 required=no_word_pending");
                end else begin
                    e = q[0];
                    chk("opcode", {26'b0, opcode}, {26'b0, e.w[31:26]});
                    chk("rs",     {27'b0, rs},     {27'b0, e.w[25:21]});
                    chk("rt",     {27'b0, rt},     {27'b0, e.w[20:16]});
                    chk("rd",     {27'b0, rd},     {27'b0, e.w[15:11]});
                    chk("shamt",  {27'b0, shamt},  {27'b0, e.w[10:6]});
                    chk("funct",  {26'b0, funct},  {26'b0, e.w[5:0]});
                    chk("imm16",  {16'b0, imm16},  {16'b0, e.w[15:0]});
                    chk("jaddr",  {6'b0, jaddr},   {6'b0, e.w[25:0]});
                    chk("EOp",    {30'b0, EOp},    {30'b0, e.eop});
`ifdef SPLIT_ILLEGAL_EN
                    chk("illegal", {31'b0, illegal}, {31'b0, e.ill});
`endif
                    if (out_ready) void'(q.pop_front());
                end
            end
        end
    end

    initial begin
        vec_t tbl[9];
        v_lui  = mk(32'h3C01F111, 2'b10, 1'b0);
        v_ori  = mk(32'h34210005, 2'b01, 1'b0);
        v_beq  = mk(32'h1022FFFE, 2'b11, 1'b0);
        v_lw   = mk(32'h8C230004, 2'b00, 1'b0);
        v_add  = mk(32'h00221820, 2'b00, 1'b0);
        v_addi = mk(32'h2001000A, 2'b00, 1'b0);
        v_andi = mk(32'h302100FF, 2'b01, 1'b0);
        v_bne  = mk(32'h1422FFFE, 2'b11, 1'b0);
        v_ones = mk(32'hFFFFFFFF, 2'b00, 1'b1);
        v_fc   = mk(32'hFC000000, 2'b00, 1'b1);
        v_badr = mk(32'h0022183F, 2'b00, 1'b1);
        tbl = '{v_lui, v_ori, v_beq, v_lw, v_add, v_addi, v_andi, v_bne, v_fc};

        // Reset held two cycles against a live all-ones input.
        cur = v_ones; instr = v_ones.w; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
        @(posedge clk); #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_EOp", {30'b0, EOp}, 32'd0);
        chk("rst_instr_cnt", {28'b0, instr_cnt}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
        chk("rst_jaddr", {6'b0, jaddr}, 32'd0);
        reset = 1'b0;

        // lui accepted, then held 5 cycles while other words are offered.
        drive(v_lui, 1'b1, 1'b0, 1'b0);
        chk("lui_valid", {31'b0, out_valid}, 32'd1);
        chk("lui_opcode", {26'b0, opcode}, 32'h0F);
        chk("lui_rt", {27'b0, rt}, 32'h01);
        chk("lui_imm16", {16'b0, imm16}, 32'hF111);
        chk("lui_EOp", {30'b0, EOp}, 32'h2);
        for (int i = 0; i < 5; i++) drive(v_lw, 1'b1, 1'b0, 1'b0);
        chk("lui_held_imm16", {16'b0, imm16}, 32'hF111);
        chk("lui_held_in_ready", {31'b0, in_ready}, 32'd0);
        drive(v_ones, 1'b0, 1'b1, 1'b0);

        // Back-to-back streaming: EOp 01, 11, 00 on consecutive cycles.
        do_reset();
        drive(v_ori, 1'b1, 1'b1, 1'b0);
        chk("stream_EOp0", {30'b0, EOp}, 32'h1);
        drive(v_beq, 1'b1, 1'b1, 1'b0);
        chk("stream_EOp1", {30'b0, EOp}, 32'h3);
        drive(v_lw, 1'b1, 1'b1, 1'b0);
        chk("stream_EOp2", {30'b0, EOp}, 32'h0);
        drive(v_ones, 1'b0, 1'b1, 1'b0);
        chk("stream_cnt", {28'b0, instr_cnt}, 32'd3);

        // R-type field split.
        drive(v_add, 1'b1, 1'b0, 1'b0);
        chk("add_rs", {27'b0, rs}, 32'd1);
        chk("add_rt", {27'b0, rt}, 32'd2);
        chk("add_rd", {27'b0, rd}, 32'd3);
        chk("add_shamt", {27'b0, shamt}, 32'd0);
        chk("add_funct", {26'b0, funct}, 32'h20);
        chk("add_EOp", {30'b0, EOp}, 32'd0);
        drive(v_ones, 1'b0, 1'b1, 1'b0);

        // Flush while holding, with in_valid high: word dropped, nothing counted or loaded.
        drive(v_addi, 1'b1, 1'b0, 1'b0);
        drive(v_lw, 1'b1, 1'b0, 1'b1);
        chk("flush_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_cnt", {28'b0, instr_cnt}, 32'd4);
        // Flush coinciding with a transfer still counts it.
        drive(v_andi, 1'b1, 1'b0, 1'b0);
        drive(v_lw, 1'b1, 1'b1, 1'b1);
        chk("flush_xfer_valid", {31'b0, out_valid}, 32'd0);
        chk("flush_xfer_cnt", {28'b0, instr_cnt}, 32'd5);

        // Illegal-word candidates load and transfer like any other word.
        drive(v_fc, 1'b1, 1'b0, 1'b0);
        drive(v_badr, 1'b1, 1'b1, 1'b0);
        drive(v_add, 1'b1, 1'b1, 1'b0);
        drive(v_ones, 1'b0, 1'b1, 1'b0);
        chk("illegal_seq_cnt", {28'b0, instr_cnt}, 32'd8);

        // Reset during a transfer: not counted, out_valid drops.
        drive(v_bne, 1'b1, 1'b0, 1'b0);
        out_ready = 1'b1;
        do_reset();
        chk("rst_xfer_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_xfer_cnt", {28'b0, instr_cnt}, 32'd0);

        // 17 transfers on a 4-bit counter wrap to 1.
        for (int i = 0; i < 17; i++) drive(tbl[i % 9], 1'b1, 1'b1, 1'b0);
        drive(v_ones, 1'b0, 1'b1, 1'b0);
        chk("wrap_cnt", {28'b0, instr_cnt}, 32'd1);
        drive(v_ones, 1'b0, 1'b0, 1'b0);

        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/instr_splitter.md
Name: instr_splitter

Overview:
- Registered instruction-split stage sitting directly upstream of the immediate extender.
- Accepts 32-bit MIPS instruction words over a valid/ready handshake and holds them in a single pipeline register.
- Presents the decoded fields opcode, rs, rt, rd, shamt, funct, imm16 and jaddr, plus the 2-bit EOp select that the extender consumes.
- Counts delivered instructions for debug.

Parameters:
- CNT_W, 16, width of the delivered-instruction counter.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state
- in_valid  input  1  upstream presents instr
- in_ready  output  1  stage can accept instr this cycle
- instr  input  32  raw instruction word
- flush  input  1  discard held instruction
- out_valid  output  1  held instruction valid
- out_ready  input  1  downstream consumes held instruction
- opcode  output  6  instr[31:26] of held word
- rs  output  5  instr[25:21]
- rt  output  5  instr[20:16]
- rd  output  5  instr[15:11]
- shamt  output  5  instr[10:6]
- funct  output  6  instr[5:0]
- imm16  output  16  instr[15:0], drives extender imm
- jaddr  output  26  instr[25:0]
- EOp  output  2  extender mode for held word
- instr_cnt  output  CNT_W  delivered-instruction count

Behaviour:
- One clock (clk); reset is synchronous and active-high.
- Reset values:
  - out_valid=0
  - held word=0, so all field outputs are 0 and EOp=00
  - instr_cnt=0
- in_ready = ~out_valid | out_ready. This is combinational, with no bubble on back-to-back transfers.
- Load: on in_valid & in_ready & ~flush, the word register takes instr and EOp is registered from the decode. out_valid=1 next cycle. Latency is 1 cycle from accept to presentation.
- Transfer out: out_valid & out_ready. If no simultaneous load occurs, out_valid clears next cycle.
- Simultaneous transfer out and load: the register takes the new word and out_valid stays 1.
- Hold: while out_valid & ~out_ready, all outputs are stable regardless of instr and in_valid.
- Flush:
  - Next cycle out_valid=0 and no load occurs, even if in_valid=1.
  - Field outputs keep their last value; they are don't-care while out_valid=0.
  - in_ready still follows its formula.
- Reset has priority over flush. Flush has priority over load.
- Field outputs are pure slices of the held word and are registered, not combinational from instr.
- EOp decode on the incoming opcode, registered together with the word:
  - 001100 andi → 01 (zero-extend)
  - 001101 ori → 01 (zero-extend)
  - 001111 lui → 10 (imm<<16)
  - 000100 beq → 11 (sign-extend <<2)
  - 000101 bne → 11 (sign-extend <<2)
  - all others, including R-type 000000, lw, sw, addi, addiu → 00 (sign-extend)
- instr_cnt:
  - Increments by 1 on each transfer out, including a transfer that coincides with flush.
  - Wraps from 2^CNT_W-1 to 0.
  - Unaffected by flush alone.
- Reset mid-transfer: the transfer is not counted, and out_valid=0 next cycle.

Optional Feature:
- Macro SPLIT_ILLEGAL_EN.
- When defined, an extra output illegal (1 bit) is registered with the word.
  - illegal=1 when the opcode is not one of 000000, 000010, 000011, 000100, 000101, 001000, 001001, 001100, 001101, 001111, 100011, 101011.
  - illegal=1 also when the opcode is 000000 and funct is not one of 100000, 100001, 100010, 100011, 100100, 100101, 101010, 000000, 001000.
  - illegal resets to 0.
  - An illegal word still loads and transfers normally.
- When not defined, the port is absent and there is no other behavioural difference.

Test Plan:
- Reset: assert reset 2 cycles with in_valid=1, instr=32'hFFFFFFFF → out_valid=0, EOp=00, instr_cnt=0, in_ready=1.
- Single accept of 32'h3C01F111 (lui), out_ready=0 → one cycle later out_valid=1, opcode=0F, rt=01, imm16=F111, EOp=10; outputs held for 5 cycles while in_valid=1 with other words; in_ready=0 throughout.
- Streaming 34210005 (ori), 1022FFFE (beq), 8C230004 (lw) with out_ready=1 every cycle → EOp sequence 01, 11, 00 on consecutive cycles, no bubbles, instr_cnt=3.
- R-type 00221820 (add) → rs=01, rt=02, rd=03, shamt=00, funct=20, EOp=00.
- Flush while holding with in_valid=1 → next cycle out_valid=0 and instr_cnt unchanged; flush together with out_ready=1 → instr_cnt+1.
- CNT_W=4 with 17 transfers → instr_cnt=1 after wrap. With SPLIT_ILLEGAL_EN, word FC000000 → illegal=1 and 00221820 → illegal=0.
